mem_arbiter: RTL and testbench

Shares one single-port unified memory between the multi-cycle CPU's instruction-fetch path and its data-access path (LW/SW). It is a req/ack handshake arbiter with a small sequencing FSM. It serialises accesses and issues one memory cycle per grant. It waits a parameterised read latency and returns data and a one-cycle acknowledge to the winning requester. Data accesses have priority, bounded by an anti-starvation limit for fetch.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; fetch is guaranteed a grant after STARVE_LIM consecutive data wins.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              grant
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int CNT_W = $clog2(LAT + 1);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wcnt;
    logic [SC_W-1:0]   r_starve;
    logic              r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_irdata;
    logic [DATA_W-1:0] r_drdata;

    logic              w_data_win;
    logic              w_any_req;

    // Fetch only overrides a competing data request once the starvation limit is reached
    assign w_data_win = d_req && (!i_req || (r_starve != SC_W'(STARVE_LIM)));
    assign w_any_req  = i_req || d_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_wcnt   <= '0;
            r_starve <= '0;
            r_grant  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_data_win;
                        r_addr  <= w_data_win ? d_addr : i_addr;
                        r_we    <= w_data_win && d_we;
                        if (w_data_win) begin
                            r_wdata <= d_wdata;
                        end
                        if (w_data_win && i_req) begin
                            if (r_starve != SC_W'(STARVE_LIM)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end else begin
                            r_starve <= '0;
                        end
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wcnt  <= CNT_W'(LAT);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt - 1'b1;
                    // Memory data is valid in the last wait cycle only
                    if (r_wcnt == CNT_W'(1)) begin
                        if (r_grant) begin
                            r_drdata <= m_rdata;
                        end else begin
                            r_irdata <= m_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_en    = (r_state == S_ACCESS);
    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign busy    = (r_state != S_IDLE);
    assign grant   = r_grant;
    assign i_ack   = (r_state == S_RESP) && !r_grant;
    assign d_ack   = (r_state == S_RESP) && r_grant;
    assign i_rdata = r_irdata;
    assign d_rdata = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-schedule model.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SLIM = 2;

    logic        CLK;
    logic        RST;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;
    logic        grant;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LAT(LAT), .STARVE_LIM(SLIM)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .grant(grant)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int tcyc   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    function automatic logic [31:0] mem_init(input int i);
        logic [31:0] v;
        v = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        case (i)
            0:  v = 32'h11111111;
            1:  v = 32'h22222222;
            2:  v = 32'h5EED0008;
            4:  v = 32'hDEADBEEF;
            16: v = 32'hCAFE0040;
            default: ;
        endcase
        return v;
    endfunction

    // Memory environment: read data appears exactly LAT cycles after the strobe
    logic [31:0] env_mem [0:255];
    logic [31:0] pipe    [0:LAT];
    assign m_rdata = pipe[LAT];

    initial begin : memory
        for (int i = 0; i < 256; i++) env_mem[i] = mem_init(i);
        for (int i = 0; i <= LAT; i++) pipe[i] = $urandom;
        forever begin
            @(negedge CLK);
            for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = (m_en && !m_we) ? env_mem[m_addr[9:2]] : $urandom;
            if (m_en && m_we) env_mem[m_addr[9:2]] = m_wdata;
        end
    end

    // Reference model: each grant schedules its strobe and completion cycle
    logic [31:0] tm_mem [0:255];
    int          mcyc    = 0;
    bit          started = 0;
    bit          tx_act  = 0;
    bit          tx_data, tx_we;
    int          tx_s, tx_ack;
    int          starve  = 0;
    logic [31:0] tx_addr, tx_wdata, tx_rdata;
    logic [31:0] ex_addr, ex_wdata, ex_irdata, ex_drdata;
    logic        ex_we;

    initial begin : model
        bit e_men, e_busy, e_iack, e_dack, done;
        for (int i = 0; i < 256; i++) tm_mem[i] = mem_init(i);
        ex_addr = '0; ex_wdata = '0; ex_irdata = '0; ex_drdata = '0; ex_we = 1'b0;
        forever begin
            @(negedge CLK);
            mcyc++;
            e_men  = tx_act && (mcyc == tx_s + 1);
            e_busy = tx_act && (mcyc > tx_s);
            e_iack = tx_act && (mcyc == tx_ack) && !tx_data;
            e_dack = tx_act && (mcyc == tx_ack) && tx_data;
            if (e_men) begin
                ex_addr = tx_addr;
                ex_we   = tx_we;
                if (tx_data) ex_wdata = tx_wdata;
            end
            if (tx_act && (mcyc == tx_ack) && !tx_we) begin
                if (tx_data) ex_drdata = tx_rdata;
                else         ex_irdata = tx_rdata;
            end
            if (started) begin
                chk("m_en", m_en, e_men);
                chk("busy", busy, e_busy);
                chk("i_ack", i_ack, e_iack);
                chk("d_ack", d_ack, e_dack);
                chk("i_rdata", i_rdata, ex_irdata);
                chk("d_rdata", d_rdata, ex_drdata);
                chk("m_addr", m_addr, ex_addr);
                chk("m_we", m_we, ex_we);
                if (e_men && ex_we) chk("m_wdata", m_wdata, ex_wdata);
                if (e_busy) chk("grant", grant, tx_data);
            end
            done = tx_act && (mcyc == tx_ack);
            if (RST) begin
                tx_act = 0; starve = 0; started = 1;
                ex_addr = '0; ex_wdata = '0; ex_irdata = '0; ex_drdata = '0; ex_we = 1'b0;
            end else if (done) begin
                tx_act = 0;
            end else if (!tx_act && (i_req || d_req)) begin
                tx_data  = d_req && (!i_req || starve != SLIM);
                starve   = (tx_data && i_req) ? ((starve < SLIM) ? starve + 1 : starve) : 0;
                tx_addr  = tx_data ? d_addr : i_addr;
                tx_we    = tx_data && d_we;
                tx_wdata = d_wdata;
                tx_rdata = tm_mem[tx_addr[9:2]];
                if (tx_we) tm_mem[tx_addr[9:2]] = tx_wdata;
                tx_s   = mcyc;
                tx_ack = mcyc + (tx_we ? 2 : 2 + LAT);
                tx_act = 1;
            end
        end
    end

    logic seen_i, seen_d;
    always @(negedge CLK) begin
        seen_i <= i_ack;
        seen_d <= d_ack;
    end

    task automatic drv_edge();
        @(posedge CLK);
        #1;
    endtask

    // which: 0 waits for the memory strobe, 1 waits for any acknowledge
    task automatic wait_sig(input int which, input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge CLK);
            if ((which == 0 && m_en) || (which == 1 && (i_ack || d_ack))) ok = 1;
        end
        if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin : stim
        int  t0, t1;
        bit  exp_g [0:5];
        RST = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        repeat (3) drv_edge();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", busy, 0);   chk("rst_grant", grant, 0);
        chk("rst_m_en", m_en, 0);   chk("rst_m_addr", m_addr, 0);
        chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);

        // Fetch read of 0x10
        drv_edge(); t0 = tcyc;
        i_req = 1; i_addr = 32'h10;
        wait_sig(0, "f_men");
        chk("f_men_cycle", tcyc - t0, 1); chk("f_m_addr", m_addr, 32'h10);
        wait_sig(1, "f_ack");
        chk("f_ack_cycle", tcyc - t0, 4); chk("f_i_ack", i_ack, 1);
        chk("f_i_rdata", i_rdata, 32'hDEADBEEF); chk("f_d_ack", d_ack, 0);
        drv_edge(); i_req = 0;
        @(negedge CLK);
        chk("f_idle", busy, 0);

        // Data write of 0x1234 to 0x20
        drv_edge(); t0 = tcyc;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234;
        wait_sig(0, "w_men");
        chk("w_men_cycle", tcyc - t0, 1); chk("w_m_we", m_we, 1); chk("w_m_wdata", m_wdata, 32'h1234);
        wait_sig(1, "w_ack");
        chk("w_ack_cycle", tcyc - t0, 2); chk("w_d_ack", d_ack, 1); chk("w_d_rdata", d_rdata, 0);
        drv_edge(); d_req = 0; d_we = 0;
        @(negedge CLK);
        chk("w_idle", busy, 0);

        // Both held: data first, then starvation forces fetch every third grant
        drv_edge();
        i_req = 1; i_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h40;
        for (int k = 0; k < 6; k++) begin
            wait_sig(0, "s_men");
            chk($sformatf("s_grant%0d", k), grant, exp_g[k]);
            if (k == 0) chk("s_m_addr", m_addr, 32'h40);
            wait_sig(1, "s_ack");
            if (k == 0) chk("s_d_rdata", d_rdata, 32'hCAFE0040);
            if (k == 5) begin
                drv_edge(); i_req = 0; d_req = 0;
            end
        end
        repeat (2) @(negedge CLK);

        // Reset in the middle of a data read
        drv_edge(); d_req = 1; d_we = 0; d_addr = 32'h60;
        drv_edge();
        drv_edge(); RST = 1;
        @(negedge CLK);
        chk("r_busy_before", busy, 1);
        drv_edge(); RST = 0; d_req = 0;
        @(negedge CLK);
        chk("r_busy", busy, 0);     chk("r_grant", grant, 0);   chk("r_m_en", m_en, 0);
        chk("r_m_we", m_we, 0);     chk("r_m_addr", m_addr, 0); chk("r_m_wdata", m_wdata, 0);
        chk("r_i_rdata", i_rdata, 0); chk("r_d_rdata", d_rdata, 0);
        chk("r_i_ack", i_ack, 0);   chk("r_d_ack", d_ack, 0);
        repeat (6) begin
            @(negedge CLK);
            chk("r_no_d_ack", d_ack, 0);
        end
        drv_edge(); t0 = tcyc; i_req = 1; i_addr = 32'h8;
        wait_sig(1, "r_fetch");
        chk("r_fetch_cycle", tcyc - t0, 2 + LAT); chk("r_fetch_data", i_rdata, 32'h5EED0008);
        drv_edge(); i_req = 0;
        repeat (2) @(negedge CLK);

        // Back-to-back fetches with a one-cycle re-request gap
        drv_edge(); i_req = 1; i_addr = 32'h0;
        wait_sig(1, "b_ack0");
        t1 = tcyc; chk("b_data0", i_rdata, 32'h11111111);
        drv_edge(); i_req = 0;
        drv_edge(); i_req = 1; i_addr = 32'h4;
        wait_sig(1, "b_ack1");
        chk("b_gap", tcyc - t1, LAT + 4); chk("b_data1", i_rdata, 32'h22222222);
        drv_edge(); i_req = 0;
        repeat (2) @(negedge CLK);

        // Randomized traffic under the handshake rules
        for (int c = 0; c < 3000; c++) begin
            drv_edge();
            RST = ($urandom_range(0, 399) == 0);
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req = 1; i_addr = {22'd0, 8'($urandom), 2'b00};
                end
            end else if (seen_i) begin
                if ($urandom_range(0, 1) == 1) i_addr = {22'd0, 8'($urandom), 2'b00};
                else i_req = 0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_we = 1'($urandom); d_wdata = $urandom;
                    d_addr = {22'd0, 8'($urandom), 2'b00};
                end
            end else if (seen_d) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_we = 1'($urandom); d_wdata = $urandom;
                    d_addr = {22'd0, 8'($urandom), 2'b00};
                end else begin
                    d_req = 0;
                end
            end
        end
        drv_edge(); RST = 0; i_req = 0; d_req = 0;
        repeat (12) @(negedge CLK);
        chk("final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
